// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA sync decoder slice.
// Contents:
//   DEF_TOTAL_COLS / DEF_TOTAL_ROWS   default frame geometry (800 x 525)
//   DEF_ACTIVE_COLS / DEF_ACTIVE_ROWS default active area (640 x 480)
//   DEF_LOCK_FRAMES                   default good frames needed for lock
//   CNT_W                             width of the row/column counters
//   sync_lock_e                       lock tracker states
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int DEF_TOTAL_COLS  = 800;
    localparam int DEF_TOTAL_ROWS  = 525;
    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_ACTIVE_ROWS = 480;
    localparam int DEF_LOCK_FRAMES = 2;
    localparam int CNT_W           = 10;

    // SEARCH: waiting for the first VSync rise to align on.
    // TRACK : aligned, counting consecutive clean frames.
    // LOCKED: enough clean frames seen; any timing error drops back to TRACK.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } sync_lock_e;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// ----------------------------------------------------------------------------
// vga_sync_decoder_if
// Bundles the sync inputs and the regenerated timing outputs of the decoder.
// Signals:
//   HSync, VSync        sync pair from the source (active-area high)
//   HSync_o, VSync_o    syncs delayed by one pixel clock
//   row, col            coordinates aligned to HSync_o / VSync_o
//   frame_start         one-cycle pulse at row 0, col 0 after a VSync rise
//   locked              timing verified against the expected geometry
// Modports:
//   master  the video source / consumer side (drives syncs, reads results)
//   slave   the decoder side (reads syncs, drives results)
// ----------------------------------------------------------------------------
interface vga_sync_decoder_if;
    import vga_pkg::*;

    logic             HSync;
    logic             VSync;
    logic             HSync_o;
    logic             VSync_o;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic             frame_start;
    logic             locked;

    modport master (
        output HSync,
        output VSync,
        input  HSync_o,
        input  VSync_o,
        input  row,
        input  col,
        input  frame_start,
        input  locked
    );

    modport slave (
        input  HSync,
        input  VSync,
        output HSync_o,
        output VSync_o,
        output row,
        output col,
        output frame_start,
        output locked
    );

endinterface

// File: rtl/vga_sync_decoder_rise_det.sv
// ----------------------------------------------------------------------------
// rise_det
// One-cycle registered delay of a synchronous input plus a rising-edge flag
// formed from the live input against its delayed copy.
// Ports:
//   clk    pixel clock
//   rst_n  asynchronous active-low reset
//   d      input level
//   q      d delayed by one clock (0 in reset)
//   rise   high for the cycle in which d is 1 and q is still 0
// ----------------------------------------------------------------------------
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    // Delayed copy of the input; also serves as the decoder's sync output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    // Combinational so the counters can react in the same cycle as the edge.
    assign rise = d & ~q;

endmodule

// File: rtl/vga_sync_decoder.sv
// ----------------------------------------------------------------------------
// vga_sync_decoder
// Receive-side VGA timing recovery. Regenerates row/column coordinates from
// an incoming HSync/VSync pair, aligned to a one-cycle-delayed copy of the
// syncs, and checks the incoming timing against the expected frame geometry
// to report lock.
//
// Parameters:
//   TOTAL_COLS   pixel clocks per line
//   TOTAL_ROWS   lines per frame
//   ACTIVE_COLS  cycles per line with HSync high
//   ACTIVE_ROWS  lines per frame with VSync high
//   LOCK_FRAMES  consecutive good frames needed for lock (1..3)
// Ports:
//   clk      pixel clock
//   rst_n    asynchronous active-low reset
//   vid      vga_sync_decoder_if.slave (syncs in, coordinates/status out)
//   err_cnt  saturating count of timing error cycles
//            (only when SYNC_ERR_CNT_EN is defined)
// Build option:
//   SYNC_ERR_CNT_EN  adds the err_cnt port and its counter
// ----------------------------------------------------------------------------
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
    parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic                clk,
    input  logic                rst_n,
    vga_sync_decoder_if.slave   vid
`ifdef SYNC_ERR_CNT_EN
    ,
    output logic [15:0]         err_cnt
`endif
);

    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(TOTAL_ROWS - 1);
    localparam logic [2:0]       LOCK_GOAL = 3'(LOCK_FRAMES);

    // Reject geometries the counters or the lock counter cannot represent.
    generate
        if (ACTIVE_COLS >= TOTAL_COLS || ACTIVE_ROWS >= TOTAL_ROWS ||
            TOTAL_COLS > (2 ** CNT_W) || TOTAL_ROWS > (2 ** CNT_W) ||
            LOCK_FRAMES < 1 || LOCK_FRAMES > 3) begin : g_bad_cfg
            $error("vga_sync_decoder: unsupported timing parameters");
        end
    endgenerate

    logic             hs_rise;
    logic             vs_rise;
    logic             hs_q;
    logic             vs_q;
    logic [CNT_W-1:0] row_q;
    logic [CNT_W-1:0] col_q;
    logic             frame_start_q;
    logic             locked_q;
    logic             at_line_end;
    logic             at_frame_end;
    logic             err;
    sync_lock_e       state;
    sync_lock_e       state_nx;
    logic [1:0]       good;
    logic [1:0]       good_nx;
    logic [2:0]       good_inc;

    rise_det u_hs_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vid.HSync),
        .q     (hs_q),
        .rise  (hs_rise)
    );

    rise_det u_vs_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vid.VSync),
        .q     (vs_q),
        .rise  (vs_rise)
    );

    assign vid.HSync_o     = hs_q;
    assign vid.VSync_o     = vs_q;
    assign vid.row         = row_q;
    assign vid.col         = col_q;
    assign vid.frame_start = frame_start_q;
    assign vid.locked      = locked_q;

    assign at_line_end  = (col_q == COL_LAST);
    assign at_frame_end = at_line_end && (row_q == ROW_LAST);

    // The counters trail the source by one clock, so a well-formed HSync or
    // VSync rise arrives while they still sit on the last column / last pixel.
    // A VSync rise takes precedence: the HSync rise that accompanies every
    // frame start is not checked separately.
    always_comb begin
        err = 1'b0;
        if (state != SEARCH) begin
            if (vs_rise) begin
                err = !at_frame_end;
            end else if (hs_rise) begin
                err = !at_line_end;
            end
        end
    end

    // Coordinate counters: free-run from reset and are realigned by every
    // VSync rise regardless of lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q         <= '0;
            col_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= vs_rise;
            if (vs_rise) begin
                row_q <= '0;
                col_q <= '0;
            end else if (at_line_end) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Lock tracker state register. locked follows the next state so that it
    // reflects a transition one clock after the deciding sync edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEARCH;
            good     <= 2'd0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_nx;
            good     <= good_nx;
            locked_q <= (state_nx == LOCKED);
        end
    end

    assign good_inc = {1'b0, good} + 3'd1;

    // Lock tracker next-state: errors reset the good-frame run, a clean
    // VSync rise extends it, and reaching the goal grants lock.
    always_comb begin
        state_nx = state;
        good_nx  = good;
        case (state)
            SEARCH: begin
                if (vs_rise) begin
                    state_nx = TRACK;
                    good_nx  = 2'd0;
                end
            end
            TRACK: begin
                if (err) begin
                    good_nx = 2'd0;
                end else if (vs_rise) begin
                    good_nx = good + 2'd1;
                    if (good_inc == LOCK_GOAL) begin
                        state_nx = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (err) begin
                    state_nx = TRACK;
                    good_nx  = 2'd0;
                end
            end
            default: begin
                state_nx = SEARCH;
                good_nx  = 2'd0;
            end
        endcase
    end

`ifdef SYNC_ERR_CNT_EN
    // Saturating error tally; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 16'd0;
        end else if (err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_decoder
// Self-checking bench for vga_sync_decoder using a reduced frame geometry.
// A directed vector table covers the first cycles after reset; a source
// generator with injected timing faults then drives the decoder while a
// position/lock reference model predicts every output each cycle.
// Honors SYNC_ERR_CNT_EN when the design is built with it.
// ----------------------------------------------------------------------------
module tb_vga_sync_decoder;
    import vga_pkg::*;

    localparam int TC    = 20;
    localparam int TR    = 12;
    localparam int AC    = 16;
    localparam int AR    = 9;
    localparam int LF    = 2;
    localparam int FRAME = TC * TR;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    vga_sync_decoder_if vid ();

`ifdef SYNC_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    vga_sync_decoder #(
        .TOTAL_COLS  (TC),
        .TOTAL_ROWS  (TR),
        .ACTIVE_COLS (AC),
        .ACTIVE_ROWS (AR),
        .LOCK_FRAMES (LF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vid)
`ifdef SYNC_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: decoder position as one linear pixel index within the
    // frame, plus the lock rules expressed as a run length of clean frames.
    bit m_hs_o;
    bit m_vs_o;
    bit m_fs;
    bit m_locked;
    int m_pos;
    int m_phase;
    int m_good;
    int m_err_cnt;

    // Source generator state and fault knobs.
    int src_row;
    int src_col;
    int glitch_row = -1;
    int glitch_col = -1;
    bit short_frame = 1'b0;
    int vs_rises = 0;

    typedef struct {
        bit h;
        bit v;
        bit ho;
        bit vo;
        int row;
        int col;
        bit fs;
        bit lk;
    } vec_t;

    vec_t vecs[9];

    task automatic check_val(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_hs_o    = 1'b0;
        m_vs_o    = 1'b0;
        m_fs      = 1'b0;
        m_locked  = 1'b0;
        m_pos     = 0;
        m_phase   = 0;
        m_good    = 0;
        m_err_cnt = 0;
    endtask

    task automatic check_output();
        check_val("hsync_o", int'(vid.HSync_o), int'(m_hs_o));
        check_val("vsync_o", int'(vid.VSync_o), int'(m_vs_o));
        check_val("row", int'(vid.row), m_pos / TC);
        check_val("col", int'(vid.col), m_pos % TC);
        check_val("frame_start", int'(vid.frame_start), int'(m_fs));
        check_val("locked", int'(vid.locked), int'(m_locked));
`ifdef SYNC_ERR_CNT_EN
        check_val("err_cnt", int'(err_cnt), m_err_cnt);
`endif
    endtask

    // Called at a negative edge: drive the syncs, advance the model across
    // the next rising edge, then compare on the following negative edge.
    task automatic apply_stimulus(input bit h, input bit v);
        bit vs_r;
        bit hs_r;
        bit e;
        vid.HSync = h;
        vid.VSync = v;
        vs_r = v && !m_vs_o;
        hs_r = h && !m_hs_o;
        e = (m_phase != 0) &&
            ((vs_r && (m_pos != FRAME - 1)) ||
             (hs_r && !vs_r && ((m_pos % TC) != TC - 1)));
        if (vs_r) vs_rises++;
        @(posedge clk);
        m_pos  = vs_r ? 0 : (m_pos + 1) % FRAME;
        m_fs   = vs_r;
        m_hs_o = h;
        m_vs_o = v;
        case (m_phase)
            0: if (vs_r) begin m_phase = 1; m_good = 0; end
            1: begin
                if (e) m_good = 0;
                else if (vs_r) begin
                    m_good++;
                    if (m_good == LF) m_phase = 2;
                end
            end
            default: if (e) begin m_phase = 1; m_good = 0; end
        endcase
        m_locked = (m_phase == 2);
        if (e && m_err_cnt < 65535) m_err_cnt++;
        @(negedge clk);
        check_output();
    endtask

    task automatic gen_step();
        bit h;
        bit v;
        h = (src_col < AC) && !((src_row == glitch_row) && (src_col == glitch_col - 1));
        v = (src_row < AR);
        apply_stimulus(h, v);
        if (src_col == TC - 1) begin
            src_col = 0;
            if (src_row == TR - 1 || (short_frame && src_row == TR - 2)) src_row = 0;
            else src_row++;
        end else begin
            src_col++;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) gen_step();
    endtask

    task automatic run_until_rise();
        int start;
        int guard;
        start = vs_rises;
        guard = 0;
        while (vs_rises == start && guard < 2 * FRAME) begin
            gen_step();
            guard++;
        end
        if (vs_rises == start) begin
            checks++;
            errors++;
            $display("[TB] FAIL rise_timeout: got no VSync rise, expected one within %0d cycles", 2 * FRAME);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_hsync_o"}, int'(vid.HSync_o), 0);
        check_val({tag, "_vsync_o"}, int'(vid.VSync_o), 0);
        check_val({tag, "_row"}, int'(vid.row), 0);
        check_val({tag, "_col"}, int'(vid.col), 0);
        check_val({tag, "_frame_start"}, int'(vid.frame_start), 0);
        check_val({tag, "_locked"}, int'(vid.locked), 0);
`ifdef SYNC_ERR_CNT_EN
        check_val({tag, "_err_cnt"}, int'(err_cnt), 0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        vid.HSync = 1'b0;
        vid.VSync = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vid.HSync = 1'b0;
        vid.VSync = 1'b0;

        //        h  v  ho vo row col fs lk
        vecs[0] = '{0, 0, 0, 0, 0, 1, 0, 0};
        vecs[1] = '{0, 0, 0, 0, 0, 2, 0, 0};
        vecs[2] = '{1, 1, 1, 1, 0, 0, 1, 0};
        vecs[3] = '{1, 1, 1, 1, 0, 1, 0, 0};
        vecs[4] = '{0, 1, 0, 1, 0, 2, 0, 0};
        vecs[5] = '{1, 1, 1, 1, 0, 3, 0, 0};
        vecs[6] = '{1, 0, 1, 0, 0, 4, 0, 0};
        vecs[7] = '{1, 1, 1, 1, 0, 0, 1, 0};
        vecs[8] = '{1, 1, 1, 1, 0, 1, 0, 0};

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Directed vectors straight out of reset.
        foreach (vecs[i]) begin
            vid.HSync = vecs[i].h;
            vid.VSync = vecs[i].v;
            @(posedge clk);
            @(negedge clk);
            check_val($sformatf("vec%0d_hsync_o", i), int'(vid.HSync_o), int'(vecs[i].ho));
            check_val($sformatf("vec%0d_vsync_o", i), int'(vid.VSync_o), int'(vecs[i].vo));
            check_val($sformatf("vec%0d_row", i), int'(vid.row), vecs[i].row);
            check_val($sformatf("vec%0d_col", i), int'(vid.col), vecs[i].col);
            check_val($sformatf("vec%0d_frame_start", i), int'(vid.frame_start), int'(vecs[i].fs));
            check_val($sformatf("vec%0d_locked", i), int'(vid.locked), int'(vecs[i].lk));
        end
`ifdef SYNC_ERR_CNT_EN
        check_val("vec_err_cnt", int'(err_cnt), 2);
`endif

        // Clean start from a generator at row 0, col 0.
        do_reset();
        src_row = 0;
        src_col = 0;
        vs_rises = 0;
        gen_step();
        check_val("first_frame_start", int'(vid.frame_start), 1);
        check_val("first_row", int'(vid.row), 0);
        check_val("first_col", int'(vid.col), 0);
        run_until_rise();
        check_val("no_lock_after_2nd_rise", int'(vid.locked), 0);
        run_until_rise();
        check_val("lock_after_3rd_rise", int'(vid.locked), 1);
        run_cycles(3 * FRAME);

        // Extra HSync rise mid-line while locked.
        glitch_row = 3;
        glitch_col = 5;
        run_cycles(3 * TC + 5);
        check_val("locked_drops_on_glitch", int'(vid.locked), 0);
`ifdef SYNC_ERR_CNT_EN
        check_val("err_cnt_one", int'(err_cnt), 1);
`endif
        glitch_row = -1;
        glitch_col = -1;
        run_cycles(FRAME - (3 * TC + 6));
        run_cycles(FRAME);
        run_cycles(1);
        check_val("relock_after_glitch", int'(vid.locked), 1);

        // One frame a line short: VSync rises early.
        short_frame = 1'b1;
        run_until_rise();
        short_frame = 1'b0;
        check_val("short_frame_row", int'(vid.row), 0);
        check_val("short_frame_col", int'(vid.col), 0);
        check_val("short_frame_unlock", int'(vid.locked), 0);
        run_until_rise();
        run_until_rise();
        check_val("relock_after_short", int'(vid.locked), 1);

        // Reset pulse in the middle of a frame.
        run_cycles(5 * TC + 6);
        do_reset();
        run_cycles(5 * FRAME);
        check_val("relock_after_reset", int'(vid.locked), 1);

        // Randomized frames with occasional faults.
        for (int f = 0; f < 12; f++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            if (kind == 2) begin
                glitch_row = int'($urandom_range(1, TR - 2));
                glitch_col = int'($urandom_range(2, AC - 1));
            end else if (kind == 3) begin
                short_frame = 1'b1;
            end
            run_until_rise();
            glitch_row = -1;
            glitch_col = -1;
            short_frame = 1'b0;
        end
        run_cycles(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
